code_packer: RTL and testbench

- Sequential stage directly downstream of the 3-input/2-output select-decode stage.
- Takes that stage's 2-bit `out` code, one code per accepted cycle, and packs consecutive codes into wide words.
- Buffers the words in a small FIFO and presents them on a valid/ready interface to the consumer (capture/compare logic).
- Also supports flushing a partially filled word.

---
 rtl/code_packer_pkg.sv | 26 ++
 rtl/code_packer_fifo.sv | 57 +++++
 rtl/code_packer.sv | 125 ++++++++++++
 tb/tb_code_packer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/code_packer_pkg.sv
// code_packer_pkg
//   Shared definitions for the code packer slice: default code/word/FIFO
//   sizes, the derived word and count widths, the word-control FSM state
//   type and the packed layout of one output FIFO entry.
package code_packer_pkg;

  localparam int DEF_CODE_W         = 2;
  localparam int DEF_CODES_PER_WORD = 4;
  localparam int DEF_DEPTH          = 4;

  localparam int WORD_W = DEF_CODE_W * DEF_CODES_PER_WORD;
  localparam int CNT_W  = $clog2(DEF_CODES_PER_WORD + 1);

  // FILL: accumulating codes. HOLD: one slot left and no FIFO room.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // One buffered word: how many codes are valid, and the packed codes.
  typedef struct packed {
    logic [CNT_W-1:0]  count;
    logic [WORD_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/code_packer_fifo.sv
// code_packer_fifo
//   First-word-fall-through synchronous FIFO holding packed words.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     push, wdata   write wdata when push (ignored when full)
//     pop           drop the head entry (ignored when empty)
//     rdata         head entry, valid whenever !empty
//     full, empty   occupancy flags from the wrapped pointer compare
//     level         number of stored entries (0..DEPTH)
module code_packer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit: equal low bits with differing wrap
  // bits means every slot is occupied.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the head is only observed while !empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/code_packer.sv
// code_packer
//   Packs consecutive CODE_W-bit codes into words of CODES_PER_WORD codes,
//   first code in the least significant slot, and hands finished (or
//   flushed partial) words to the consumer through an FWFT FIFO.
//   Ports:
//     clk, rst               clock, asynchronous active-high reset
//     in_valid/in_code       incoming code, accepted when in_ready is high
//     in_ready               room for another code
//     flush / flush_ack      level request to emit the partial word, and
//                            the pulse marking the cycle it was taken
//     out_valid/out_ready    consumer handshake on the FIFO head
//     out_data/out_count     head word and its number of valid codes
module code_packer
  import code_packer_pkg::*;
#(
  parameter int CODE_W         = DEF_CODE_W,
  parameter int CODES_PER_WORD = DEF_CODES_PER_WORD,
  parameter int DEPTH          = DEF_DEPTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  input  logic [CODE_W-1:0]                     in_code,
  output logic                                  in_ready,
  input  logic                                  flush,
  output logic                                  flush_ack,
  output logic                                  out_valid,
  output logic [CODE_W*CODES_PER_WORD-1:0]      out_data,
  output logic [$clog2(CODES_PER_WORD+1)-1:0]   out_count,
  input  logic                                  out_ready
);

  localparam int DW = CODE_W * CODES_PER_WORD;
  localparam int CW = $clog2(CODES_PER_WORD + 1);
  localparam int AW = $clog2(DEPTH);

  localparam logic [CW-1:0] LAST_SLOT  = CW'(CODES_PER_WORD - 1);
  localparam logic [CW-1:0] WORD_CODES = CW'(CODES_PER_WORD);
  localparam logic [AW:0]   FIFO_CAP   = (AW + 1)'(DEPTH);

  state_t          state;
  logic [CW-1:0]   acc_cnt;
  logic [CW-1:0]   next_cnt;
  logic [DW-1:0]   acc;
  logic [DW-1:0]   next_acc;
  logic            accept;
  logic            word_done;
  logic            flush_take;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [AW:0]     fifo_level;
  logic [AW:0]     next_level;
  logic [CW+DW-1:0] fifo_wdata;
  logic [CW+DW-1:0] fifo_rdata;

  // HOLD is exactly "last slot pending and FIFO full", so in_ready comes
  // straight from the registered state and never sees out_ready.
  assign in_ready = (state == FILL);
  assign accept   = in_valid && in_ready;

  // Accumulator with the current code folded in, so a flush in the same
  // cycle as an accept emits the word including that code.
  always_comb begin
    next_acc = acc;
    next_cnt = acc_cnt;
    if (accept) begin
      for (int k = 0; k < CODES_PER_WORD; k++) begin
        if (acc_cnt == CW'(k)) next_acc[k*CODE_W +: CODE_W] = in_code;
      end
      next_cnt = acc_cnt + 1'b1;
    end
  end

  assign word_done  = accept && (next_cnt == WORD_CODES);
  assign flush_take = flush && !fifo_full && ((acc_cnt != '0) || accept);
  assign flush_ack  = flush_take;
  assign push       = word_done || flush_take;
  assign pop        = out_valid && out_ready;
  assign fifo_wdata = {next_cnt, next_acc};
  assign next_level = fifo_level + (AW + 1)'(push) - (AW + 1)'(pop);

  // Accumulator and word-control FSM. The next state is computed from the
  // post-edge count and FIFO level so HOLD releases right after a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FILL;
      acc     <= '0;
      acc_cnt <= '0;
    end else begin
      if (push) begin
        acc     <= '0;
        acc_cnt <= '0;
      end else begin
        acc     <= next_acc;
        acc_cnt <= next_cnt;
      end
      if (!push && (next_cnt == LAST_SLOT) && (next_level == FIFO_CAP))
        state <= HOLD;
      else
        state <= FILL;
    end
  end

  code_packer_fifo #(
    .WIDTH (CW + DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? fifo_rdata[DW-1:0] : '0;
  assign out_count = out_valid ? fifo_rdata[CW+DW-1:DW] : '0;

endmodule

// File: tb/tb_code_packer.sv
// tb_code_packer
//   Directed bench for code_packer. Every cycle the bench predicts in_ready,
//   flush_ack and the FIFO head from its own queue of expected words; words
//   are queued when the stimulus would push them and popped when the
//   consumer takes them. Named cases add fixed expected words on top.
module tb_code_packer;
  import code_packer_pkg::*;

  localparam int CPW = DEF_CODES_PER_WORD;
  localparam int DEP = DEF_DEPTH;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [1:0]        in_code;
  logic              in_ready;
  logic              flush;
  logic              flush_ack;
  logic              out_valid;
  logic [WORD_W-1:0] out_data;
  logic [CNT_W-1:0]  out_count;
  logic              out_ready;

  code_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .in_ready  (in_ready),
    .flush     (flush),
    .flush_ack (flush_ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int pops   = 0;

  entry_t            sb[$];
  int                m_cnt = 0;
  logic [WORD_W-1:0] m_acc = '0;

  // Hard stop so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle starting at a falling edge: drive inputs, predict and
  // check every output, update the expected-word queue, advance a cycle.
  task automatic apply_stimulus(input logic v, input logic [1:0] c, input logic f,
                                input logic r, output logic accepted, output logic acked);
    entry_t e;
    logic   exp_ready;
    logic   take;
    int     n;
    in_valid  = v;
    in_code   = c;
    flush     = f;
    out_ready = r;
    #1;
    n         = sb.size();
    exp_ready = (m_cnt < CPW - 1) || (n < DEP);
    check("in_ready", in_ready, exp_ready);
    accepted  = v && exp_ready;
    take      = f && (n < DEP) && ((m_cnt > 0) || accepted);
    check("flush_ack", flush_ack, take);
    check("out_valid", out_valid, n != 0);
    if (n != 0) begin
      check("out_data", out_data, sb[0].data);
      check("out_count", out_count, sb[0].count);
      if (r) begin
        void'(sb.pop_front());
        pops++;
      end
    end else begin
      check("out_data_idle", out_data, 0);
      check("out_count_idle", out_count, 0);
    end
    if (accepted) begin
      m_acc[m_cnt*2 +: 2] = c;
      m_cnt++;
    end
    if ((accepted && m_cnt == CPW) || take) begin
      e.data  = m_acc;
      e.count = CNT_W'(m_cnt);
      sb.push_back(e);
      m_acc = '0;
      m_cnt = 0;
    end
    acked = take;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Fixed-value check of the head word presented right now.
  task automatic check_output(input string tag, input logic [WORD_W-1:0] data,
                              input logic [CNT_W-1:0] count);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, data);
    check({tag, "_count"}, out_count, count);
  endtask

  initial begin
    logic acc_f;
    logic ack_f;
    int   sent;
    int   pops_start;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_code   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state.
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_count", out_count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_flush_ack", flush_ack, 0);
    @(negedge clk);

    // Full word 1,2,3,0 with the consumer always ready.
    apply_stimulus(1, 2'd1, 0, 1, acc_f, ack_f);
    apply_stimulus(1, 2'd2, 0, 1, acc_f, ack_f);
    apply_stimulus(1, 2'd3, 0, 1, acc_f, ack_f);
    apply_stimulus(1, 2'd0, 0, 1, acc_f, ack_f);
    #1;
    check_output("word_39", 8'h39, 3'd4);
    apply_stimulus(0, 2'd0, 0, 1, acc_f, ack_f);

    // Partial flush of 3,3, then a flush with nothing pending.
    apply_stimulus(1, 2'd3, 0, 1, acc_f, ack_f);
    apply_stimulus(1, 2'd3, 0, 1, acc_f, ack_f);
    apply_stimulus(0, 2'd0, 1, 1, acc_f, ack_f);
    check("flush_taken", ack_f, 1);
    #1;
    check_output("word_0f", 8'h0F, 3'd2);
    apply_stimulus(0, 2'd0, 1, 1, acc_f, ack_f);
    check("flush_empty_ignored", ack_f, 0);
    apply_stimulus(0, 2'd0, 0, 1, acc_f, ack_f);

    // Back-pressure: 20 codes of 2 with the consumer stalled, then released.
    sent       = 0;
    pops_start = pops;
    for (int i = 0; i < 60; i++) begin
      if (i == 24) begin
        #1;
        check("stall_in_ready", in_ready, 0);
        check("stall_sent", sent, 19);
        check("stall_fifo_words", sb.size(), 4);
      end
      apply_stimulus(sent < 20, 2'd2, 0, i >= 25, acc_f, ack_f);
      if (acc_f) sent++;
    end
    check("stream_sent", sent, 20);
    check("stream_words", pops - pops_start, 5);
    check("stream_residue", m_cnt, 0);
    check("stream_drained", out_valid, 0);

    // Accept and flush in the same cycle.
    apply_stimulus(1, 2'd1, 0, 1, acc_f, ack_f);
    apply_stimulus(1, 2'd2, 1, 1, acc_f, ack_f);
    check("flush_with_accept", ack_f, 1);
    #1;
    check_output("word_09", 8'h09, 3'd2);
    apply_stimulus(0, 2'd0, 0, 1, acc_f, ack_f);

    // Asynchronous reset with one stored word and a half-filled accumulator.
    for (int i = 0; i < 6; i++) apply_stimulus(1, 2'd3, 0, 0, acc_f, ack_f);
    in_valid = 1'b0;
    #1;
    check("pre_rst_valid", out_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    sb.delete();
    m_cnt = 0;
    m_acc = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(1, 2'd0, 0, 1, acc_f, ack_f);
    apply_stimulus(1, 2'd1, 0, 1, acc_f, ack_f);
    apply_stimulus(1, 2'd2, 0, 1, acc_f, ack_f);
    apply_stimulus(1, 2'd3, 0, 1, acc_f, ack_f);
    #1;
    check_output("word_e4", 8'hE4, 3'd4);
    apply_stimulus(0, 2'd0, 0, 1, acc_f, ack_f);
    apply_stimulus(0, 2'd0, 0, 1, acc_f, ack_f);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
